// File: rtl/pio_pkg.sv
// rtl/pio_pkg.sv - register map, CTRL/CLKDIV/WRAP field positions and controller state type
package pio_pkg;

  localparam logic [2:0] ADDR_CTRL   = 3'd0;
  localparam logic [2:0] ADDR_CLKDIV = 3'd1;
  localparam logic [2:0] ADDR_WRAP   = 3'd2;
  localparam logic [2:0] ADDR_INSTR  = 3'd3;
  localparam logic [2:0] ADDR_PC     = 3'd4;

  localparam int CTRL_ENABLE_BIT      = 0;
  localparam int CTRL_RESTART_BIT     = 1;
  localparam int CTRL_DIV_RESTART_BIT = 2;
  localparam int CTRL_OVERRUN_BIT     = 8;

  localparam int CLKDIV_INT_LSB  = 16;
  localparam int CLKDIV_FRAC_LSB = 8;

  localparam int WRAP_TOP_LSB    = 8;
  localparam int WRAP_BOTTOM_LSB = 0;

  localparam logic [4:0] WRAP_TOP_RESET    = 5'h00;
  localparam logic [4:0] WRAP_BOTTOM_RESET = 5'h1F;

  typedef enum logic [1:0] {
    DISABLED = 2'd0,
    RUN      = 2'd1,
    RESTART  = 2'd2
  } sm_ctrl_state_t;

endpackage

// File: rtl/clk_divider.sv
// rtl/clk_divider.sv - integer.fraction divider producing a one-cycle tick per period
module clk_divider #(
  parameter int INT_W  = 16,
  parameter int FRAC_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [INT_W-1:0]  div_int,
  input  logic [FRAC_W-1:0] div_frac,
  input  logic              run,
  input  logic              clear,
  output logic              tick
);

  logic [INT_W-1:0]  int_q;
  logic [FRAC_W-1:0] frac_q;
  logic [FRAC_W-1:0] acc;
  logic              carry;
  logic [INT_W:0]    cnt;
  logic [INT_W+1:0]  int_eff;
  logic [INT_W+1:0]  period_len;
  logic [INT_W+1:0]  cnt_next;

  // Period length: int of 0 stands for 2^INT_W, plus one cycle when the last tick carried
  always_comb begin
    int_eff    = (int_q == '0) ? {2'b01, {INT_W{1'b0}}} : {2'b00, int_q};
    period_len = int_eff + {{(INT_W+1){1'b0}}, carry};
    cnt_next   = {1'b0, cnt} + {{(INT_W+1){1'b0}}, 1'b1};
    tick       = run && !clear && (cnt_next == period_len);
  end

  // Counter/accumulator; divider settings are only picked up at a period boundary or while idle
  always_ff @(posedge clk) begin
    if (rst) begin
      int_q  <= {{(INT_W-1){1'b0}}, 1'b1};
      frac_q <= '0;
      acc    <= '0;
      carry  <= 1'b0;
      cnt    <= '0;
    end else begin
      if (clear) begin
        cnt   <= '0;
        acc   <= '0;
        carry <= 1'b0;
      end else if (tick) begin
        cnt            <= '0;
        {carry, acc}   <= {1'b0, acc} + {1'b0, frac_q};
      end else if (run) begin
        cnt <= cnt_next[INT_W:0];
      end
      if (clear || tick || !run) begin
        int_q  <= div_int;
        frac_q <= div_frac;
      end
    end
  end

endmodule

// File: rtl/sm_controller.sv
// rtl/sm_controller.sv - PIO state-machine control registers, step strobe, restart and forced exec
module sm_controller
  import pio_pkg::*;
#(
  parameter int DIV_INT_W  = 16,
  parameter int DIV_FRAC_W = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        reg_wr_en,
  input  logic        reg_rd_en,
  input  logic [2:0]  reg_addr,
  input  logic [31:0] reg_wdata,
  output logic [31:0] reg_rdata,
  input  logic [4:0]  pc,
  output logic        sm_step,
  output logic        sm_restart,
  output logic        exec_valid,
  output logic [15:0] exec_instr,
  output logic [4:0]  wrap_top,
  output logic [4:0]  wrap_bottom
);

  sm_ctrl_state_t         state;
  logic                   enable;
  logic                   pending;
  logic                   exec_overrun;
  logic [15:0]            instr_word;
  logic [DIV_INT_W-1:0]   div_int;
  logic [DIV_FRAC_W-1:0]  div_frac;

  logic        ctrl_wr, clkdiv_wr, wrap_wr, instr_wr;
  logic        restart_wr, div_restart_wr, enable_next;
  logic        div_run, div_clear, tick;
  logic [31:0] rd_mux;

  // Write decode; a restart write also resets the divider on the same edge
  always_comb begin
    ctrl_wr        = reg_wr_en && (reg_addr == ADDR_CTRL);
    clkdiv_wr      = reg_wr_en && (reg_addr == ADDR_CLKDIV);
    wrap_wr        = reg_wr_en && (reg_addr == ADDR_WRAP);
    instr_wr       = reg_wr_en && (reg_addr == ADDR_INSTR);
    restart_wr     = ctrl_wr && reg_wdata[CTRL_RESTART_BIT];
    div_restart_wr = ctrl_wr && reg_wdata[CTRL_DIV_RESTART_BIT];
    enable_next    = ctrl_wr ? reg_wdata[CTRL_ENABLE_BIT] : enable;
    div_run        = (state == RUN);
    div_clear      = (state == RESTART) || restart_wr || div_restart_wr;
  end

  // Read mux; pulse bits and unmapped addresses read as zero
  always_comb begin
    rd_mux = '0;
    case (reg_addr)
      ADDR_CTRL: begin
        rd_mux[CTRL_ENABLE_BIT]  = enable;
        rd_mux[CTRL_OVERRUN_BIT] = exec_overrun;
      end
      ADDR_CLKDIV: begin
        rd_mux[CLKDIV_INT_LSB +: DIV_INT_W]   = div_int;
        rd_mux[CLKDIV_FRAC_LSB +: DIV_FRAC_W] = div_frac;
      end
      ADDR_WRAP: begin
        rd_mux[WRAP_TOP_LSB +: 5]    = wrap_top;
        rd_mux[WRAP_BOTTOM_LSB +: 5] = wrap_bottom;
      end
      ADDR_INSTR: rd_mux[15:0] = instr_word;
      ADDR_PC:    rd_mux[4:0]  = pc;
      default:    rd_mux = '0;
    endcase
  end

  clk_divider #(
    .INT_W  (DIV_INT_W),
    .FRAC_W (DIV_FRAC_W)
  ) u_clk_divider (
    .clk      (clk),
    .rst      (rst),
    .div_int  (div_int),
    .div_frac (div_frac),
    .run      (div_run),
    .clear    (div_clear),
    .tick     (tick)
  );

  // Software-visible configuration registers and registered read data
  always_ff @(posedge clk) begin
    if (rst) begin
      enable      <= 1'b0;
      div_int     <= DIV_INT_W'(1);
      div_frac    <= '0;
      wrap_top    <= WRAP_TOP_RESET;
      wrap_bottom <= WRAP_BOTTOM_RESET;
      reg_rdata   <= '0;
    end else begin
      enable <= enable_next;
      if (clkdiv_wr) begin
        div_int  <= reg_wdata[CLKDIV_INT_LSB +: DIV_INT_W];
        div_frac <= reg_wdata[CLKDIV_FRAC_LSB +: DIV_FRAC_W];
      end
      if (wrap_wr) begin
        wrap_top    <= reg_wdata[WRAP_TOP_LSB +: 5];
        wrap_bottom <= reg_wdata[WRAP_BOTTOM_LSB +: 5];
      end
      if (reg_rd_en) reg_rdata <= rd_mux;
    end
  end

  // Control FSM with registered strobes; restart wins over everything and drops any pending exec
  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= DISABLED;
      sm_step      <= 1'b0;
      sm_restart   <= 1'b0;
      exec_valid   <= 1'b0;
      exec_instr   <= '0;
      pending      <= 1'b0;
      instr_word   <= '0;
      exec_overrun <= 1'b0;
    end else begin
      if (restart_wr) begin
        state      <= RESTART;
        sm_restart <= 1'b1;
        sm_step    <= 1'b0;
        exec_valid <= 1'b0;
        pending    <= 1'b0;
      end else begin
        state      <= enable_next ? RUN : DISABLED;
        sm_restart <= 1'b0;
        case (state)
          RUN: begin
            sm_step    <= tick;
            exec_valid <= tick && pending;
            if (tick && pending) begin
              exec_instr <= instr_word;
              pending    <= 1'b0;
            end
          end
          DISABLED: begin
            sm_step    <= pending;
            exec_valid <= pending;
            if (pending) begin
              exec_instr <= instr_word;
              pending    <= 1'b0;
            end
          end
          default: begin
            sm_step    <= 1'b0;
            exec_valid <= 1'b0;
          end
        endcase
        if (instr_wr) begin
          if (pending) begin
            exec_overrun <= 1'b1;
          end else begin
            pending    <= 1'b1;
            instr_word <= reg_wdata[15:0];
          end
        end
      end
      if (ctrl_wr && reg_wdata[CTRL_OVERRUN_BIT]) exec_overrun <= 1'b0;
    end
  end

endmodule
